pipelined_carry_skip_adder: RTL and testbench

//   N-bit carry-skip adder, pipelined one stage per group of BLOCKS_PER_STAGE skip blocks.

---
 rtl/pipelined_carry_skip_adder_pkg.sv | 29 ++
 rtl/pipelined_carry_skip_adder_block.sv | 32 +++
 rtl/pipelined_carry_skip_adder.sv | 140 ++++++++++++++
 tb/tb_pipelined_carry_skip_adder.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipelined_carry_skip_adder_pkg.sv
// csa_pkg: sizing helpers and the per-stage pipeline record shared by the
// pipelined carry-skip adder and its carry_skip_block sub-module.
package csa_pkg;

    // Widest operand the stage record can carry; wider adders need this raised.
    localparam int CSA_MAX_N = 128;

    // Number of sum bits finished by one pipeline stage.
    function automatic int csa_stage_width(input int block_size, input int blocks_per_stage);
        return block_size * blocks_per_stage;
    endfunction

    // Number of pipeline stages needed to cover all N bits.
    function automatic int csa_stages(input int n, input int block_size, input int blocks_per_stage);
        return n / csa_stage_width(block_size, blocks_per_stage);
    endfunction

    // Contents of one stage slot: bits below the stage's group are finished sum
    // bits, bits at and above it are still raw operand bits, and carry is the
    // carry entering this stage's group.
    typedef struct packed {
        logic                 valid;
        logic                 carry;
        logic [CSA_MAX_N-1:0] sum;
        logic [CSA_MAX_N-1:0] a;
        logic [CSA_MAX_N-1:0] b;
    } csa_stage_t;

endpackage

// File: rtl/pipelined_carry_skip_adder_block.sv
// carry_skip_block: one combinational carry-skip block. Ripples the sum through
// BLOCK_SIZE bits and bypasses the ripple carry when every bit propagates.
module carry_skip_block #(
    parameter int BLOCK_SIZE = 4
) (
    input  logic [BLOCK_SIZE-1:0] a,
    input  logic [BLOCK_SIZE-1:0] b,
    input  logic                  cin,
    output logic [BLOCK_SIZE-1:0] sum,
    output logic                  cout,
    output logic                  prop_all
);

    logic ripple_cout;

    // Ripple-carry sum across the block, keeping the final ripple carry.
    always_comb begin
        logic c;
        c = cin;
        sum = '0;
        for (int i = 0; i < BLOCK_SIZE; i++) begin
            sum[i] = a[i] ^ b[i] ^ c;
            c      = (a[i] & b[i]) | ((a[i] ^ b[i]) & c);
        end
        ripple_cout = c;
    end

    // When every bit propagates the carry-in passes straight through the skip mux.
    assign prop_all = &(a ^ b);
    assign cout     = prop_all ? cin : ripple_cout;

endmodule

// File: rtl/pipelined_carry_skip_adder.sv
// pipelined_carry_skip_adder: N-bit carry-skip adder pipelined one stage per
// group of BLOCKS_PER_STAGE skip blocks, valid/ready on input and output.
// Optional feature macro: CSA_OVERFLOW_EN adds the registered signed-overflow output ovf.
module pipelined_carry_skip_adder
    import csa_pkg::*;
#(
    parameter int N                = 16,
    parameter int BLOCK_SIZE       = 4,
    parameter int BLOCKS_PER_STAGE = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] sum,
    output logic         cout
`ifdef CSA_OVERFLOW_EN
    ,
    output logic         ovf
`endif
);

    localparam int W      = csa_stage_width(BLOCK_SIZE, BLOCKS_PER_STAGE);
    localparam int STAGES = csa_stages(N, BLOCK_SIZE, BLOCKS_PER_STAGE);

    if (BLOCK_SIZE < 1 || BLOCKS_PER_STAGE < 1) begin : g_bad_block
        $error("BLOCK_SIZE and BLOCKS_PER_STAGE must both be at least 1");
    end
    if (N % W != 0) begin : g_bad_width
        $error("N must be a multiple of BLOCK_SIZE*BLOCKS_PER_STAGE");
    end
    if (N > CSA_MAX_N) begin : g_too_wide
        $error("N exceeds CSA_MAX_N in csa_pkg");
    end

    for (genvar s = 0; s < STAGES; s++) begin : g_stage
        csa_stage_t                  stage_q;
        csa_stage_t                  stage_d;
        csa_stage_t                  upstream;
        csa_stage_t                  result;
        logic                        ready;
        logic                        down_ready;
        logic [W-1:0]                grp_sum;
        logic [BLOCKS_PER_STAGE-1:0] blk_prop;
        logic                        grp_prop;
        logic                        grp_carry;

        if (s == 0) begin : g_head
            // Stage 0 is fed from the input port with an empty partial sum.
            always_comb begin
                upstream        = '0;
                upstream.valid  = in_valid;
                upstream.carry  = cin;
                upstream.a[N-1:0] = a;
                upstream.b[N-1:0] = b;
            end
        end else begin : g_body
            assign upstream = g_stage[s-1].result;
        end

        if (s == STAGES - 1) begin : g_tail
            assign down_ready = out_ready;
        end else begin : g_link
            assign down_ready = g_stage[s+1].ready;
        end

        // A slot accepts new content when it is empty or its content moves on,
        // so bubbles collapse even while the output is stalled.
        assign ready = ~stage_q.valid | down_ready;

        for (genvar j = 0; j < BLOCKS_PER_STAGE; j++) begin : g_blk
            logic                  c_in;
            logic                  c_out;
            logic [BLOCK_SIZE-1:0] s_out;

            if (j == 0) begin : g_first
                assign c_in = stage_q.carry;
            end else begin : g_chain
                assign c_in = g_blk[j-1].c_out;
            end

            carry_skip_block #(
                .BLOCK_SIZE(BLOCK_SIZE)
            ) u_block (
                .a        (stage_q.a[s*W + j*BLOCK_SIZE +: BLOCK_SIZE]),
                .b        (stage_q.b[s*W + j*BLOCK_SIZE +: BLOCK_SIZE]),
                .cin      (c_in),
                .sum      (s_out),
                .cout     (c_out),
                .prop_all (blk_prop[j])
            );

            assign grp_sum[j*BLOCK_SIZE +: BLOCK_SIZE] = s_out;
        end

        // A group that propagates in every block passes its carry-in straight on.
        assign grp_prop  = &blk_prop;
        assign grp_carry = grp_prop ? stage_q.carry : g_blk[BLOCKS_PER_STAGE-1].c_out;

        // Stage content after this stage's group has been summed.
        always_comb begin
            result                = stage_q;
            result.sum[s*W +: W]  = grp_sum;
            result.carry          = grp_carry;
        end

        // Load upstream content when ready, otherwise hold.
        always_comb begin
            stage_d = stage_q;
            if (ready) begin
                stage_d = upstream;
            end
        end

        // Stage slot register; reset empties it and zeroes its data.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                stage_q <= '0;
            end else begin
                stage_q <= stage_d;
            end
        end
    end

    assign in_ready  = g_stage[0].ready;
    assign out_valid = g_stage[STAGES-1].result.valid;
    assign sum       = g_stage[STAGES-1].result.sum[N-1:0];
    assign cout      = g_stage[STAGES-1].result.carry;

`ifdef CSA_OVERFLOW_EN
    // Signed overflow: the carry entering the sign bit disagrees with the carry leaving it.
    assign ovf = (g_stage[STAGES-1].stage_q.a[N-1] ^ g_stage[STAGES-1].stage_q.b[N-1] ^ sum[N-1]) ^ cout;
`endif

endmodule

// File: tb/tb_pipelined_carry_skip_adder.sv
// Testbench for pipelined_carry_skip_adder (N=16, BLOCK_SIZE=4, one block per stage).
module tb_pipelined_carry_skip_adder;

    localparam int N = 16;

    typedef struct {
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic         cin;
        logic [N-1:0] sum;
        logic         cout;
        logic         ovf;
    } vec_t;

    typedef struct {
        logic [N-1:0] sum;
        logic         cout;
        logic         ovf;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         inValid;
    logic         inReady;
    logic [N-1:0] opA;
    logic [N-1:0] opB;
    logic         carryIn;
    logic         outValid;
    logic         outReady;
    logic [N-1:0] sumOut;
    logic         coutOut;
    logic         ovfOut;

    int   checkCount = 0;
    int   failCount  = 0;
    int   cyc        = 0;
    exp_t expQueue[$];
    vec_t vecs[17];

    pipelined_carry_skip_adder #(
        .N(N), .BLOCK_SIZE(4), .BLOCKS_PER_STAGE(1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (inValid),
        .in_ready  (inReady),
        .a         (opA),
        .b         (opB),
        .cin       (carryIn),
        .out_valid (outValid),
        .out_ready (outReady),
        .sum       (sumOut),
        .cout      (coutOut)
`ifdef CSA_OVERFLOW_EN
        ,
        .ovf       (ovfOut)
`endif
    );

`ifndef CSA_OVERFLOW_EN
    assign ovfOut = 1'b0;
`endif

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic vec_t mkVec(input logic [N-1:0] a, input logic [N-1:0] b, input logic cin,
                                   input logic [N-1:0] s, input logic co, input logic ov);
        vec_t v;
        v.a = a; v.b = b; v.cin = cin; v.sum = s; v.cout = co; v.ovf = ov;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic applyStimulus(input vec_t v, output int accCycle);
        int waited;
        bit done;
        exp_t e;
        waited = 0;
        done = 1'b0;
        accCycle = -1;
        opA = v.a; opB = v.b; carryIn = v.cin; inValid = 1'b1;
        while (!done) begin
            @(negedge clk);
            if (inReady) begin
                e.sum = v.sum; e.cout = v.cout; e.ovf = v.ovf;
                expQueue.push_back(e);
                accCycle = cyc;
                done = 1'b1;
            end else begin
                waited++;
                if (waited > 200) begin
                    checkCount++;
                    failCount++;
                    $display("[TB] FAIL accept timeout: a=%0h b=%0h not accepted within 200 cycles", v.a, v.b);
                    done = 1'b1;
                end
            end
        end
        @(posedge clk);
        #1;
        inValid = 1'b0;
    endtask

    task automatic waitDrain();
        int waited;
        waited = 0;
        while ((expQueue.size() != 0 || outValid) && waited < 300) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 300) begin
            checkCount++;
            failCount++;
            $display("[TB] FAIL drain timeout: %0d results outstanding, required 0", expQueue.size());
        end
        @(posedge clk);
        #1;
    endtask

    // Monitor: pops the scoreboard on every output transfer and checks AXI-style hold.
    initial begin
        logic         heldValid;
        logic [N-1:0] heldSum;
        logic         heldCout;
        logic         heldOvf;
        exp_t         e;
        heldValid = 1'b0;
        heldSum = '0; heldCout = 1'b0; heldOvf = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                heldValid = 1'b0;
            end else begin
                if (heldValid) begin
                    checkOutput("hold out_valid", 32'(outValid), 32'd1);
                    checkOutput("hold sum", 32'(sumOut), 32'(heldSum));
                    checkOutput("hold cout", 32'(coutOut), 32'(heldCout));
`ifdef CSA_OVERFLOW_EN
                    checkOutput("hold ovf", 32'(ovfOut), 32'(heldOvf));
`endif
                end
                if (outValid && outReady) begin
                    if (expQueue.size() == 0) begin
                        checkCount++;
                        failCount++;
                        $display("[TB] FAIL unexpected result: sum=%0h cout=%0b with empty scoreboard", sumOut, coutOut);
                    end else begin
                        e = expQueue.pop_front();
                        checkOutput("result sum", 32'(sumOut), 32'(e.sum));
                        checkOutput("result cout", 32'(coutOut), 32'(e.cout));
`ifdef CSA_OVERFLOW_EN
                        checkOutput("result ovf", 32'(ovfOut), 32'(e.ovf));
`endif
                    end
                end
                heldValid = outValid && !outReady;
                heldSum = sumOut; heldCout = coutOut; heldOvf = ovfOut;
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", checkCount, failCount);
        $fatal(1, "[TB] watchdog expired");
    end

    // Main sequence of directed scenarios.
    initial begin
        int acc;
        int dummy;
        int waited;
        int staleSeen;

        vecs[0]  = mkVec(16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0);
        vecs[1]  = mkVec(16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0);
        vecs[2]  = mkVec(16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1);
        vecs[3]  = mkVec(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
        vecs[4]  = mkVec(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
        vecs[5]  = mkVec(16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0);
        vecs[6]  = mkVec(16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0);
        vecs[7]  = mkVec(16'h0F0F, 16'hF0F0, 1'b1, 16'h0000, 1'b1, 1'b0);
        vecs[8]  = mkVec(16'hAAAA, 16'h5555, 1'b0, 16'hFFFF, 1'b0, 1'b0);
        vecs[9]  = mkVec(16'h7000, 16'h1000, 1'b0, 16'h8000, 1'b0, 1'b1);
        vecs[10] = mkVec(16'h8001, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b0);
        vecs[11] = mkVec(16'h0001, 16'h0002, 1'b1, 16'h0004, 1'b0, 1'b0);
        vecs[12] = mkVec(16'hC000, 16'hC000, 1'b0, 16'h8000, 1'b1, 1'b0);
        vecs[13] = mkVec(16'h1111, 16'h2222, 1'b0, 16'h3333, 1'b0, 1'b0);
        vecs[14] = mkVec(16'h4444, 16'h1111, 1'b1, 16'h5556, 1'b0, 1'b0);
        vecs[15] = mkVec(16'h0100, 16'h0100, 1'b0, 16'h0200, 1'b0, 1'b0);
        vecs[16] = mkVec(16'h0007, 16'h0009, 1'b1, 16'h0011, 1'b0, 1'b0);

        rst = 1'b1; inValid = 1'b0; opA = '0; opB = '0; carryIn = 1'b0; outReady = 1'b1;

        // Reset held for three cycles: outputs quiet, then ready after release.
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset out_valid", 32'(outValid), 32'd0);
        checkOutput("reset sum", 32'(sumOut), 32'd0);
        checkOutput("reset cout", 32'(coutOut), 32'd0);
`ifdef CSA_OVERFLOW_EN
        checkOutput("reset ovf", 32'(ovfOut), 32'd0);
`endif
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("in_ready after reset", 32'(inReady), 32'd1);
        @(posedge clk);
        #1;

        // Single op and its latency.
        $display("[TB] single op latency");
        applyStimulus(vecs[0], acc);
        waited = 0;
        @(negedge clk);
        while (!outValid && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        checkOutput("latency cycles", 32'(cyc - acc), 32'd4);
        waitDrain();

        // Full skip chains and overflow corner cases.
        $display("[TB] skip chain and overflow vectors");
        for (int i = 1; i <= 4; i++) begin
            applyStimulus(vecs[i], dummy);
        end
        waitDrain();

        // Backpressure: fill the pipe, then drain with a toggling out_ready.
        $display("[TB] backpressure");
        outReady = 1'b0;
        for (int i = 5; i <= 8; i++) begin
            applyStimulus(vecs[i], dummy);
        end
        @(negedge clk);
        checkOutput("in_ready when full", 32'(inReady), 32'd0);
        checkOutput("out_valid when full", 32'(outValid), 32'd1);
        @(posedge clk);
        #1;
        fork
            begin
                int d;
                for (int i = 9; i <= 12; i++) begin
                    applyStimulus(vecs[i], d);
                end
            end
            begin
                for (int k = 0; k < 30; k++) begin
                    outReady = ~outReady;
                    @(posedge clk);
                    #1;
                end
                outReady = 1'b1;
            end
        join
        waitDrain();

        // Asynchronous reset with work in flight.
        $display("[TB] reset mid-flight");
        outReady = 1'b0;
        for (int i = 13; i <= 15; i++) begin
            applyStimulus(vecs[i], dummy);
        end
        repeat (2) @(posedge clk);
        #2;
        checkOutput("out_valid before reset", 32'(outValid), 32'd1);
        rst = 1'b1;
        expQueue.delete();
        #1;
        checkOutput("async reset out_valid", 32'(outValid), 32'd0);
        checkOutput("async reset sum", 32'(sumOut), 32'd0);
        @(posedge clk);
        #3;
        rst = 1'b0;
        outReady = 1'b1;
        staleSeen = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (outValid) staleSeen++;
        end
        checkOutput("stale results after reset", 32'(staleSeen), 32'd0);
        @(posedge clk);
        #1;
        applyStimulus(vecs[16], dummy);
        waitDrain();

        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    end

endmodule
